// File: rtl/bnn_pkg.sv
// Shared constants and buffer state type for the BNN image input path.
package bnn_pkg;

    localparam int unsigned IMG_BITS = 904;  // 900 pixels + 4 pad bits
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned PAD_BITS = 4;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } buf_state_t;

endpackage

// File: rtl/img_frame_buffer.sv
// Collects a serial MSB-first byte stream into one packed binary image frame and
// holds it stable, with a full flag, until the frame is explicitly cleared.
module img_frame_buffer
    import bnn_pkg::*;
#(
    parameter int unsigned IMG_BITS  = bnn_pkg::IMG_BITS,
    parameter int unsigned BYTE_W    = bnn_pkg::BYTE_W,
    parameter int unsigned PAD_BITS  = bnn_pkg::PAD_BITS,
    localparam int unsigned NUM_BYTES = IMG_BITS / BYTE_W,
    localparam int unsigned CNT_W     = $clog2(NUM_BYTES + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BYTE_W-1:0]   rx_byte,
    input  logic                rx_valid,
    output logic                rx_ready,
    input  logic                buffer_clear,
    output logic [IMG_BITS-1:0] img_out,
    output logic                img_buffer_full,
    output logic [CNT_W-1:0]    byte_count,
    output logic                overflow
);

    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_BYTES - 1);
    // Keeps the high bits of the final byte; the low PAD_BITS are frame padding.
    localparam logic [BYTE_W-1:0] PAD_MASK = ~BYTE_W'((2 ** PAD_BITS) - 1);

    buf_state_t          state;
    buf_state_t          state_next;
    logic [CNT_W-1:0]    count;
    logic                ovf;
    logic [IMG_BITS-1:0] frame;
    logic                accept;
    logic                last_byte;
    logic [BYTE_W-1:0]   wr_byte;

    // Clear has priority: a byte offered in the clear cycle is dropped.
    assign accept    = rx_valid && rx_ready && !buffer_clear;
    assign last_byte = (count == LAST_IDX);

    // Next-state decode for the fill sequence.
    always_comb begin
        state_next = state;
        if (buffer_clear) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY, FILLING: begin
                    if (accept) begin
                        state_next = last_byte ? FULL : FILLING;
                    end
                end
                FULL:    state_next = FULL;
                default: state_next = EMPTY;
            endcase
        end
    end

    // Handshake and full flag derive directly from the registered state, so full
    // rises on the same edge that writes the final byte.
    always_comb begin
        rx_ready        = (state != FULL);
        img_buffer_full = (state == FULL);
    end

    // State, byte counter and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            if (buffer_clear) begin
                count <= '0;
                ovf   <= 1'b0;
            end else begin
                if (accept) begin
                    count <= count + 1'b1;
                end
                if (rx_valid && (state == FULL)) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    // Pad bits of the final byte are forced low before being stored.
    always_comb begin
        wr_byte = rx_byte;
        if (last_byte) begin
            wr_byte = rx_byte & PAD_MASK;
        end
    end

    // Frame register: byte k lands at the k-th byte lane counted from the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame <= '0;
        end else if (buffer_clear) begin
            frame <= '0;
        end else if (accept) begin
            for (int k = 0; k < int'(NUM_BYTES); k++) begin
                if (count == CNT_W'(k)) begin
                    frame[IMG_BITS-1-BYTE_W*k -: BYTE_W] <= wr_byte;
                end
            end
        end
    end

    assign img_out    = frame;
    assign byte_count = count;
    assign overflow   = ovf;

endmodule
